fp_addsub_seq: RTL and testbench

- Parametrised, multi-cycle IEEE-754-style floating-point add/subtract unit for the FPU coprocessor datapath.
- Captures two packed operands on a start handshake, then steps through align, add, normalize and round/pack states.
- Returns the packed result with done and status flags.
- Normalization is iterative, one bit per cycle; a full leading-zero priority shifter is not used.

---
 rtl/fp_addsub_seq.sv | 276 +++++++++++++++++++++++++++
 tb/tb_fp_addsub_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle floating-point add/subtract (align, add, iterative normalize, round/pack).
// Optional macro FPU_ROUND_NEAREST_EVEN_EN enables round-to-nearest-even (one extra cycle); default truncates.
module fp_addsub_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   op,
    input  logic [EXP_W+MAN_W:0]   data1,
    input  logic [EXP_W+MAN_W:0]   data2,
    output logic                   busy,
    output logic                   done,
    output logic [EXP_W+MAN_W:0]   floatRes,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   invalid
);
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int SIG_W = MAN_W + 4;               // {hidden, frac, G, R, S}
    localparam int SUM_W = MAN_W + 5;               // plus carry
    localparam int XE_W  = EXP_W + 2;               // signed working exponent
    localparam int SH_W  = $clog2(SIG_W);
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EXP_W-1:0] SH_MAX_E = EXP_W'(MAN_W + 3);
    localparam logic signed [XE_W-1:0] XE_ONE = 1;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_PACK, S_DONE} state_t;

    state_t state_q, state_d;
    logic busy_q, busy_d, done_q, done_d;
    logic ovf_q, ovf_d, unf_q, unf_d, inv_q, inv_d;
    logic [W-1:0] res_q, res_d;

    logic [W-1:0] opa_q, opa_d, opb_q, opb_d, spec_res_q, spec_res_d;
    logic spec_q, spec_d, spec_inv_q, spec_inv_d;
    logic sign_q, sign_d, sign_b_q, sign_b_d;
    logic signed [XE_W-1:0] exp_q, exp_d;
    logic [SIG_W-1:0] sig_a_q, sig_a_d, sig_b_q, sig_b_d;
    logic [SUM_W-1:0] sum_q, sum_d;

    logic sa, sb;
    logic [EXP_W-1:0] ea, eb, big_e, sml_e, exp_diff;
    logic [MAN_W-1:0] fa, fb, big_f, sml_f;
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap, big_s, sml_s;
    logic [SH_W-1:0] shamt;
    logic [SIG_W-1:0] sig_small, sig_shr, lost_mask;
    logic sticky_in;
    logic sp_hit, sp_inv;
    logic [W-1:0] sp_res;
    logic [SUM_W-1:0] sum_add, sum_sub, sum_nxt;
    logic [W-1:0] pk_res;
    logic pk_ovf, pk_unf, pk_inv;

    assign {sa, ea, fa} = opa_q;
    assign {sb, eb, fb} = opb_q;
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_nan  = (ea == EXP_ONES) && (fa != '0);
    assign b_nan  = (eb == EXP_ONES) && (fb != '0);
    assign a_inf  = (ea == EXP_ONES) && (fa == '0);
    assign b_inf  = (eb == EXP_ONES) && (fb == '0);

    assign swap  = {eb, fb} > {ea, fa};
    assign big_s = swap ? sb : sa;
    assign sml_s = swap ? sa : sb;
    assign big_e = swap ? eb : ea;
    assign sml_e = swap ? ea : eb;
    assign big_f = swap ? fb : fa;
    assign sml_f = swap ? fa : fb;

    // Saturating barrel shift of the smaller operand; shifted-out bits collapse into sticky.
    assign exp_diff  = big_e - sml_e;
    assign shamt     = (exp_diff > SH_MAX_E) ? SH_W'(SH_MAX_E) : SH_W'(exp_diff);
    assign sig_small = {1'b1, sml_f, 3'b000};
    assign sig_shr   = sig_small >> shamt;
    assign lost_mask = ~({SIG_W{1'b1}} << shamt);
    assign sticky_in = |(sig_small & lost_mask);

    always_comb begin
        sp_hit = 1'b1;
        sp_inv = 1'b0;
        sp_res = '0;
        if (a_nan || b_nan) begin
            sp_res = QNAN;
        end else if (a_inf && b_inf) begin
            if (sa != sb) begin
                sp_res = QNAN;
                sp_inv = 1'b1;
            end else begin
                sp_res = opa_q;
            end
        end else if (a_inf) begin
            sp_res = opa_q;
        end else if (b_inf) begin
            sp_res = opb_q;
        end else if (a_zero) begin
            sp_res = b_zero ? {sa & sb, {(W-1){1'b0}}} : opb_q;
        end else if (b_zero) begin
            sp_res = opa_q;
        end else begin
            sp_hit = 1'b0;
        end
    end

    assign sum_add = {1'b0, sig_a_q} + {1'b0, sig_b_q};
    assign sum_sub = {1'b0, sig_a_q} - {1'b0, sig_b_q};
    assign sum_nxt = (sign_q == sign_b_q) ? sum_add : sum_sub;

    always_comb begin
        pk_res = '0;
        pk_ovf = 1'b0;
        pk_unf = 1'b0;
        pk_inv = 1'b0;
        if (spec_q) begin
            pk_res = spec_res_q;
            pk_inv = spec_inv_q;
        end else if (sum_q == '0) begin
            pk_res = '0;
        end else if (!exp_q[XE_W-1] && (exp_q[XE_W-2:0] >= {1'b0, EXP_ONES})) begin
            pk_res = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
            pk_ovf = 1'b1;
        end else if (exp_q[XE_W-1] || (exp_q == '0)) begin
            pk_res = {sign_q, {(W-1){1'b0}}};
            pk_unf = 1'b1;
        end else begin
            pk_res = {sign_q, exp_q[EXP_W-1:0], sum_q[SUM_W-3:3]};
        end
    end

`ifdef FPU_ROUND_NEAREST_EVEN_EN
    logic rnd_up;
    logic [MAN_W+1:0] rnd_sig;
    assign rnd_up  = sum_q[2] & (sum_q[1] | sum_q[0] | sum_q[3]);
    assign rnd_sig = {1'b0, sum_q[SUM_W-2:3]} + {{(MAN_W+1){1'b0}}, rnd_up};
`endif

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        res_d      = res_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        inv_d      = inv_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        spec_d     = spec_q;
        spec_inv_d = spec_inv_q;
        spec_res_d = spec_res_q;
        sign_d     = sign_q;
        sign_b_d   = sign_b_q;
        exp_d      = exp_q;
        sig_a_d    = sig_a_q;
        sig_b_d    = sig_b_q;
        sum_d      = sum_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    opa_d   = data1;
                    opb_d   = {data2[W-1] ^ op, data2[W-2:0]};
                    busy_d  = 1'b1;
                    state_d = S_ALIGN;
                end
            end
            S_ALIGN: begin
                spec_d     = sp_hit;
                spec_inv_d = sp_inv;
                spec_res_d = sp_res;
                sign_d     = big_s;
                sign_b_d   = sml_s;
                exp_d      = {2'b00, big_e};
                sig_a_d    = {1'b1, big_f, 3'b000};
                sig_b_d    = {sig_shr[SIG_W-1:1], sig_shr[0] | sticky_in};
                state_d    = S_ADD;
            end
            S_ADD: begin
                sum_d = sum_nxt;
                if (sum_nxt == '0) sign_d = 1'b0;
                state_d = S_NORM;
            end
            // One bit of normalization per cycle until the hidden bit lands in place.
            S_NORM: begin
                if (spec_q || (sum_q == '0)) begin
                    state_d = S_ROUND;
                end else if (sum_q[SUM_W-1]) begin
                    sum_d   = {1'b0, sum_q[SUM_W-1:2], sum_q[1] | sum_q[0]};
                    exp_d   = exp_q + XE_ONE;
                    state_d = S_ROUND;
                end else if (sum_q[SUM_W-2]) begin
                    state_d = S_ROUND;
                end else begin
                    sum_d = {sum_q[SUM_W-2:0], 1'b0};
                    exp_d = exp_q - XE_ONE;
                end
            end
`ifdef FPU_ROUND_NEAREST_EVEN_EN
            S_ROUND: begin
                if (!spec_q) begin
                    if (rnd_sig[MAN_W+1]) begin
                        sum_d = {1'b0, rnd_sig[MAN_W+1:1], 3'b000};
                        exp_d = exp_q + XE_ONE;
                    end else begin
                        sum_d = {1'b0, rnd_sig[MAN_W:0], 3'b000};
                    end
                end
                state_d = S_PACK;
            end
            S_PACK: begin
                res_d   = pk_res;
                ovf_d   = pk_ovf;
                unf_d   = pk_unf;
                inv_d   = pk_inv;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_DONE;
            end
`else
            S_ROUND: begin
                res_d   = pk_res;
                ovf_d   = pk_ovf;
                unf_d   = pk_unf;
                inv_d   = pk_inv;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_DONE;
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            inv_q   <= inv_d;
        end
    end

    always_ff @(posedge clk) begin
        opa_q      <= opa_d;
        opb_q      <= opb_d;
        spec_q     <= spec_d;
        spec_inv_q <= spec_inv_d;
        spec_res_q <= spec_res_d;
        sign_q     <= sign_d;
        sign_b_q   <= sign_b_d;
        exp_q      <= exp_d;
        sig_a_q    <= sig_a_d;
        sig_b_q    <= sig_b_d;
        sum_q      <= sum_d;
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign floatRes  = res_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign invalid   = inv_q;
endmodule

// File: tb/tb_fp_addsub_seq.sv
// Self-checking bench for fp_addsub_seq: vector table with scoreboard, plus reset-abort and busy-start sequences.
`timescale 1ns/1ps
module tb_fp_addsub_seq;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
`ifdef FPU_ROUND_NEAREST_EVEN_EN
    localparam int LAT = 5;
    localparam logic [31:0] RNE_RES = 32'h3F800002;
`else
    localparam int LAT = 4;
    localparam logic [31:0] RNE_RES = 32'h3F800001;
`endif

    logic clk = 1'b0;
    logic reset, start, op;
    logic [31:0] data1, data2, floatRes;
    logic busy, done, overflow, underflow, invalid;

    always #5 clk = ~clk;

    fp_addsub_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .data1(data1), .data2(data2), .busy(busy), .done(done),
        .floatRes(floatRes), .overflow(overflow), .underflow(underflow), .invalid(invalid)
    );

    typedef struct {
        string       name;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        op;
        logic [31:0] res;
        logic [2:0]  flags;   // {overflow, underflow, invalid}
        int          k;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flags;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[12];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic o, input logic [31:0] res, input logic [2:0] fl,
                          input int k, input bit pulse_busy);
        exp_t e;
        int cyc;
        bit seen;
        e.res = res;
        e.flags = fl;
        e.lat = LAT + k;
        data1 = a;
        data2 = b;
        op = o;
        start = 1'b1;
        sb_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        seen = 1'b0;
        check({name, " busy"}, {31'b0, busy}, 32'd1);
        while (!seen && cyc < 60) begin
            if (pulse_busy && cyc == 1) begin
                start = 1'b1;
                data1 = 32'h3F800000;
                data2 = 32'h3F800000;
                op = 1'b0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no done after %0d cycles", name, cyc);
            void'(sb_q.pop_front());
            return;
        end
        e = sb_q.pop_front();
        check({name, " result"}, floatRes, e.res);
        check({name, " flags"}, {29'b0, overflow, underflow, invalid}, {29'b0, e.flags});
        check({name, " latency"}, cyc, e.lat);
        check({name, " busy_at_done"}, {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        check({name, " done_pulse"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int extra;
        vecs[0]  = '{"one_plus_one",  32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 0};
        vecs[1]  = '{"three_min_one", 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000, 0};
        vecs[2]  = '{"exact_zero",    32'h3FC00000, 32'h3FC00000, 1'b1, 32'h00000000, 3'b000, 0};
        vecs[3]  = '{"overflow",      32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b100, 0};
        vecs[4]  = '{"inf_min_inf",   32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b001, 0};
        vecs[5]  = '{"tie_even",      32'h3F800001, 32'h33800000, 1'b0, RNE_RES,      3'b000, 0};
        vecs[6]  = '{"norm_k2",       32'h3F800000, 32'h3F400000, 1'b1, 32'h3E800000, 3'b000, 2};
        vecs[7]  = '{"underflow",     32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 3'b010, 23};
        vecs[8]  = '{"neg_result",    32'h3F800000, 32'h40400000, 1'b1, 32'hC0000000, 3'b000, 0};
        vecs[9]  = '{"zero_plus_x",   32'h00000000, 32'h40490FDB, 1'b0, 32'h40490FDB, 3'b000, 0};
        vecs[10] = '{"nan_in",        32'h7FC12345, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000, 0};
        vecs[11] = '{"ninf_plus_fin", 32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 3'b000, 0};

        reset = 1'b1;
        start = 1'b0;
        op = 1'b0;
        data1 = '0;
        data2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset floatRes", floatRes, 32'h0);
        check("reset flags", {29'b0, overflow, underflow, invalid}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].name, vecs[i].d1, vecs[i].d2, vecs[i].op,
                   vecs[i].res, vecs[i].flags, vecs[i].k, 1'b0);
        end

        // Abort 3.0-1.0 while in NORM; outputs clear asynchronously.
        data1 = 32'h40400000;
        data2 = 32'h3F800000;
        op = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midnorm reset busy", {31'b0, busy}, 32'd0);
        check("midnorm reset done", {31'b0, done}, 32'd0);
        check("midnorm reset floatRes", floatRes, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        run_op("after_reset", 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000, 0, 1'b0);

        // Start pulsed while busy must be ignored: no second result follows.
        run_op("big_plus_one", 32'h4E800000, 32'h3F800000, 1'b0, 32'h4E800000, 3'b000, 0, 1'b1);
        extra = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (done || busy) extra++;
        end
        check("ignored start activity", extra, 32'd0);
        check("held result", floatRes, 32'h4E800000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
